// File: rtl/frame_word_packer_pkg.sv
// Shared types and default geometry for the frame word packer.
// Package frame_pack_pkg is imported by word_fifo2 and frame_word_packer.
package frame_pack_pkg;

    localparam int DEF_H_PIX  = 480;
    localparam int DEF_V_PIX  = 360;
    localparam int DEF_WORD_W = 24;
    localparam int DEF_ADDR_W = 13;

    localparam int WORDS_PER_FRAME = DEF_H_PIX * DEF_V_PIX / DEF_WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pack_state_t;

    typedef struct packed {
        logic                  bank;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_WORD_W-1:0] data;
    } fb_word_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry FIFO of frame-buffer words; push and pop may coincide in any fill
// state, including full, where the incoming word takes the slot being popped.
module word_fifo2
    import frame_pack_pkg::*;
#(
    parameter type T = fb_word_t
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    T           mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_word_packer.sv
// Packs the serial pixel stream MSB-first into words written to a double-banked
// frame buffer. Optional per-frame checksum: define FRAME_WORD_PACKER_CHECKSUM_EN.
module frame_word_packer
    import frame_pack_pkg::*;
#(
    parameter int H_PIX  = DEF_H_PIX,
    parameter int V_PIX  = DEF_V_PIX,
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              vid_start,
    input  logic              bit_valid,
    input  logic              received_bit,
    output logic              fb_wr_valid,
    input  logic              fb_wr_ready,
    output logic              fb_wr_bank,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [WORD_W-1:0] fb_wr_data,
    output logic              display_bank,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              overflow,
    output logic [15:0]       frame_checksum
);

    localparam int FRAME_WORDS = H_PIX * V_PIX / WORD_W;
    localparam int BIT_CNT_W   = $clog2(WORD_W);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_W - 1);

    // Local word type so non-default geometries still line up with the FIFO.
    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } word_t;

    pack_state_t          state_q, state_d;
    logic [WORD_W-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]    wr_word_cnt_q, wr_word_cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 display_bank_q, display_bank_d;
    logic                 frame_done_q, frame_done_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic                 overflow_q, overflow_d;

    logic  push;
    logic  pop;
    logic  frame_end_pop;
    logic  fifo_full;
    logic  fifo_empty;
    word_t push_word;
    word_t head_word;

    word_fifo2 #(
        .T (word_t)
    ) u_fifo (
        .clk_i       (CLK_40),
        .rst_n_i     (reset),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .head_o      (head_word),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pop           = !fifo_empty && fb_wr_ready;
    assign frame_end_pop = pop && (head_word.addr == LAST_ADDR);

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        wr_word_cnt_d  = wr_word_cnt_q;
        wr_bank_d      = wr_bank_q;
        display_bank_d = display_bank_q;
        frame_done_d   = frame_end_pop;
        frame_count_d  = frame_count_q;
        overflow_d     = overflow_q;
        push           = 1'b0;
        push_word      = '{bank: wr_bank_q, addr: wr_word_cnt_q,
                           data: {shift_q[WORD_W-2:0], received_bit}};

        if (frame_end_pop) begin
            frame_count_d  = frame_count_q + 16'd1;
            display_bank_d = head_word.bank;
        end

        case (state_q)
            IDLE: begin
                if (vid_start) begin
                    state_d   = RUN;
                    bit_cnt_d = '0;
                end
            end
            RUN, DRAIN: begin
                // FIFO order puts old-frame words first, so a new-bank head means none remain.
                if (state_q == DRAIN && (fifo_empty || head_word.bank == wr_bank_q)) begin
                    state_d = RUN;
                end
                if (bit_valid) begin
                    shift_d = push_word.data;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (fifo_full && !pop) begin
                            overflow_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                        if (wr_word_cnt_q == LAST_ADDR) begin
                            wr_word_cnt_d = '0;
                            wr_bank_d     = ~wr_bank_q;
                            state_d       = DRAIN;
                        end else begin
                            wr_word_cnt_d = wr_word_cnt_q + ADDR_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            wr_word_cnt_q  <= '0;
            wr_bank_q      <= 1'b0;
            display_bank_q <= 1'b1;
            frame_done_q   <= 1'b0;
            frame_count_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            wr_word_cnt_q  <= wr_word_cnt_d;
            wr_bank_q      <= wr_bank_d;
            display_bank_q <= display_bank_d;
            frame_done_q   <= frame_done_d;
            frame_count_q  <= frame_count_d;
            overflow_q     <= overflow_d;
        end
    end

`ifdef FRAME_WORD_PACKER_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] checksum_q, checksum_d;
    logic [15:0] acc_sum;

    assign acc_sum = acc_q + 16'(head_word.data);

    always_comb begin
        acc_d      = acc_q;
        checksum_d = checksum_q;
        if (pop) begin
            acc_d = acc_sum;
            if (frame_end_pop) begin
                checksum_d = acc_sum;
                acc_d      = '0;
            end
        end
    end

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end

    assign frame_checksum = checksum_q;
`else
    assign frame_checksum = '0;
`endif

    assign fb_wr_valid  = !fifo_empty;
    assign fb_wr_bank   = head_word.bank;
    assign fb_wr_addr   = head_word.addr;
    assign fb_wr_data   = head_word.data;
    assign display_bank = display_bank_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;
    assign overflow     = overflow_q;

endmodule

// File: doc/frame_word_packer.md
Name: frame_word_packer

Overview:
- Downstream of the SPI bit-receive stage. Consumes the serial video bitstream (received_bit qualified by a one-cycle strobe) in the CLK_40 domain.
- Packs bits MSB-first into WORD_W-bit pixel words and writes them over a valid/ready port into a double-banked 1bpp frame buffer.
- Counts words per frame, swaps banks at end of frame and reports frame progress and overflow.

Parameters:
- H_PIX, 480, active pixels per line.
- V_PIX, 360, active lines per frame.
- WORD_W, 24, bits per packed word; H_PIX*V_PIX must be a multiple of WORD_W.
- ADDR_W, 13, word address width; must satisfy 2**ADDR_W >= H_PIX*V_PIX/WORD_W.

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- vid_start  in  1  level; arms the packer; sampled in IDLE only.
- bit_valid  in  1  one-cycle strobe; received_bit is valid this cycle.
- received_bit  in  1  serial pixel bit, first bit = pixel 0 of the frame.
- fb_wr_valid  out  1  write request to the frame buffer.
- fb_wr_ready  in  1  frame buffer accepts the write when high with valid.
- fb_wr_bank  out  1  bank being written.
- fb_wr_addr  out  ADDR_W  word address within the bank.
- fb_wr_data  out  WORD_W  packed word; bit WORD_W-1 = earliest pixel.
- display_bank  out  1  bank that is complete and safe to scan out (= ~fb_wr_bank).
- frame_done  out  1  one-cycle pulse when the last word of a frame is accepted.
- frame_count  out  16  number of completed frames.
- overflow  out  1  sticky overflow error.
- frame_checksum  out  16  see Optional Feature.

Behaviour:
- Reset values: all outputs are 0, except display_bank = 1. Internal state: shift register, bit counter, word counter, FIFO pointers and FSM all cleared; FSM = IDLE.
- Constant WORDS_PER_FRAME = H_PIX*V_PIX/WORD_W (7200 at defaults).
- FSM states: IDLE, RUN, DRAIN.
- IDLE: bit_valid is ignored. When vid_start = 1, go to RUN on the next cycle with bit_cnt = 0.
- RUN, on each bit_valid:
  - shift = {shift[WORD_W-2:0], received_bit}; bit_cnt increments.
  - When bit_cnt reaches WORD_W-1, the completed word (including the current bit) is pushed into a 2-entry word FIFO the same cycle, and bit_cnt wraps to 0.
  - The push carries addr = wr_word_cnt. wr_word_cnt increments on push.
  - Push latency: the word appears on fb_wr_* one cycle after the completing bit_valid, when the FIFO was empty.
- DRAIN: entered when the pushed word is the last word of the frame (wr_word_cnt = WORDS_PER_FRAME-1).
  - bit_valid continues to be accepted and packed into the next frame's words.
  - Those pushes go out with fb_wr_bank already toggled.
  - Return to RUN when the FIFO holds no words of the old frame.
- Output port:
  - fb_wr_valid = FIFO non-empty.
  - The head word is presented on fb_wr_data/fb_wr_addr/fb_wr_bank. These must stay stable while valid=1 and ready=0.
  - Pop occurs on valid & ready. A push and a pop in the same cycle are legal in any fill state, including full.
- Frame end: when the pop that is accepted carries addr = WORDS_PER_FRAME-1:
  - frame_done pulses that cycle (registered, visible the next cycle);
  - frame_count increments, wrapping at 65535 -> 0;
  - display_bank toggles so that it equals the bank just completed.
- Bank toggling: the write bank toggles at push of the last word; the address counter wraps to 0 at the same time.
- Overflow: a word completes while the FIFO is full and no pop occurs that cycle.
  - The word is dropped, overflow is set and stays set until reset.
  - wr_word_cnt still advances, so the frame alignment is preserved.
- vid_start deasserting mid-frame has no effect. Only reset returns the block to IDLE.
- Reset asserted mid-frame: immediate asynchronous clear. A partial word is discarded, and no write is issued for it.

Optional Feature:
- Macro: FRAME_WORD_PACKER_CHECKSUM_EN.
- Enabled:
  - A 16-bit accumulator adds the zero-extended low 16 bits of each accepted (popped) word, modulo 2**16.
  - On frame_done, frame_checksum is loaded with the final sum and the accumulator restarts from 0.
- Disabled: frame_checksum is tied to 0 and no accumulator logic is generated.

Decomposition:
- Package frame_pack_pkg contains:
  - localparams WORDS_PER_FRAME and default H_PIX/V_PIX/WORD_W;
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} pack_state_t;
  - typedef struct packed {bank, addr, data} fb_word_t.
- Sub-module word_fifo2: a 2-entry FIFO of fb_word_t with push, pop, full, empty and simultaneous push/pop support.

Test Plan:
- Reset, then vid_start, then 24 bit_valid pulses with bits 0xA5C3F0 MSB-first, with fb_wr_ready = 1:
  - one write, data = 0xA5C3F0, addr = 0, bank = 0;
  - fb_wr_valid rises one cycle after the 24th strobe.
- Bit strobes before vid_start: 30 pulses in IDLE produce no writes. After arming, the first word contains only post-arm bits.
- Full frame streamed with fb_wr_ready = 1:
  - 7200 writes with addr 0..7199 on bank 0;
  - a single frame_done pulse; frame_count = 1; display_bank = 0;
  - the next word goes to addr 0 on bank 1.
- Backpressure: fb_wr_ready = 0 while 2 words complete.
  - fb_wr_valid holds, with data/addr stable; no overflow.
  - A 3rd completed word sets overflow = 1 and is never written.
  - Subsequent addresses skip by one.
- Mid-frame reset: assert reset = 0 after 10 bits of word 5.
  - All outputs clear; FSM = IDLE; no partial write.
  - Re-arming restarts at addr 0 on bank 0.
- With FRAME_WORD_PACKER_CHECKSUM_EN: a frame of all-ones bits gives frame_checksum = (7200*0xFFFF) mod 2**16 = 0xE3E0. Without the macro, frame_checksum stays 0.
